// File: rtl/alu_issue_stage.sv
// alu_issue_stage: command FIFO feeding registered ALU operands,
// with a valid/ready result register and divide-by-zero guard.
module alu_issue_stage #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [7:0]                 cmd_a,
   input  logic [7:0]                 cmd_b,
   input  logic [3:0]                 cmd_fun,
   output logic [7:0]                 alu_a,
   output logic [7:0]                 alu_b,
   output logic [3:0]                 alu_fun,
   input  logic [7:0]                 alu_out,
   input  logic                       alu_arith,
   input  logic                       alu_logic,
   input  logic                       alu_cmp,
   input  logic                       alu_shift,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [7:0]                 res_data,
   output logic [3:0]                 res_flags,
   output logic [3:0]                 res_fun,
   output logic                       res_dz,
   output logic [$clog2(DEPTH):0]     fifo_count,
   output logic                       busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [3:0] FUN_DIV = 4'b0011;
   localparam logic [3:0] FUN_NOP = 4'b1111;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      HOLD
   } state_t;

   state_t state, state_n;

   logic [7:0]    q_a   [DEPTH];
   logic [7:0]    q_b   [DEPTH];
   logic [3:0]    q_fun [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [CW-1:0] count;

   logic push;
   logic pop;
   logic cap;
   logic rel;
   logic dz;

   assign cmd_ready  = (count < FULL);
   assign push       = cmd_valid && cmd_ready;
   assign fifo_count = count;
   assign busy       = (state != IDLE) || (count != '0);
   assign dz         = (alu_fun == FUN_DIV) && (alu_b == 8'h00);

   // FIFO storage: written on accepted commands only
   always_ff @(posedge clk) begin
      if (push) begin
         q_a[wptr]   <= cmd_a;
         q_b[wptr]   <= cmd_b;
         q_fun[wptr] <= cmd_fun;
      end
   end

   // FIFO pointers and occupancy; push and pop may coincide
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // Next-state, pop, capture and release decisions
   always_comb begin
      state_n = state;
      pop     = 1'b0;
      cap     = 1'b0;
      rel     = 1'b0;
      unique case (state)
         IDLE: begin
            if (count != '0) begin
               pop     = 1'b1;
               state_n = EXEC;
            end
         end
         EXEC: begin
            cap     = 1'b1;
            state_n = HOLD;
         end
         HOLD: begin
            if (res_valid && res_ready) begin
               rel = 1'b1;
               if (count != '0) begin
                  pop     = 1'b1;
                  state_n = EXEC;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Operand registers load the FIFO head on every pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a   <= 8'h00;
         alu_b   <= 8'h00;
         alu_fun <= FUN_NOP;
      end else if (pop) begin
         alu_a   <= q_a[rptr];
         alu_b   <= q_b[rptr];
         alu_fun <= q_fun[rptr];
      end
   end

   // Result register: capture at end of EXEC, hold until handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_data  <= 8'h00;
         res_flags <= 4'h0;
         res_fun   <= 4'h0;
         res_dz    <= 1'b0;
      end else if (cap) begin
         res_valid <= 1'b1;
         res_data  <= dz ? 8'hFF : alu_out;
         res_flags <= {alu_shift, alu_cmp, alu_logic, alu_arith};
         res_fun   <= alu_fun;
         res_dz    <= dz;
      end else if (rel) begin
         res_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: table vectors plus scoreboard for alu_issue_stage,
// with a behavioural ALU closing the loop on alu_* ports.
module tb_alu_issue_stage;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_a;
   logic [7:0] cmd_b;
   logic [3:0] cmd_fun;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [3:0] alu_fun;
   logic [7:0] alu_out;
   logic [3:0] afl;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_data;
   logic [3:0] res_flags;
   logic [3:0] res_fun;
   logic       res_dz;
   logic [2:0] fifo_count;
   logic       busy;

   typedef struct packed {
      logic [7:0] d;
      logic [3:0] fl;
      logic [3:0] fn;
      logic       dz;
   } exp_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] f;
      logic [7:0] d;
      logic [3:0] fl;
      logic       dz;
   } vec_t;

   exp_t   sb [$];
   int     hs [$];
   int     cyc = 0;
   int     checks = 0;
   int     errors = 0;
   vec_t   tbl [12];

   always #5 clk = ~clk;

   alu_issue_stage #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .cmd_fun    (cmd_fun),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_fun    (alu_fun),
      .alu_out    (alu_out),
      .alu_arith  (afl[0]),
      .alu_logic  (afl[1]),
      .alu_cmp    (afl[2]),
      .alu_shift  (afl[3]),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_flags  (res_flags),
      .res_fun    (res_fun),
      .res_dz     (res_dz),
      .fifo_count (fifo_count),
      .busy       (busy)
   );

   // Behavioural ALU: returns {flags, data}
   function automatic logic [11:0] alu_f(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input logic [3:0] f);
      logic [7:0] d;
      logic [3:0] fl;
      d  = 8'h00;
      fl = 4'h0;
      case (f)
         4'h0: begin d = a + b; fl = 4'b0001; end
         4'h1: begin d = a - b; fl = 4'b0001; end
         4'h2: begin d = a * b; fl = 4'b0001; end
         4'h3: begin d = (b == 0) ? 8'h00 : a / b; fl = 4'b0001; end
         4'h4: begin d = {7'd0, a < b};  fl = 4'b0100; end
         4'h5: begin d = {7'd0, a > b};  fl = 4'b0100; end
         4'h6: begin d = {7'd0, a != b}; fl = 4'b0100; end
         4'h7: begin d = {7'd0, a >= b}; fl = 4'b0100; end
         4'h8: begin d = a & b; fl = 4'b0010; end
         4'h9: begin d = a | b; fl = 4'b0010; end
         4'hA: begin d = {7'd0, a == b}; fl = 4'b0010; end
         4'hB: begin d = a ^ b; fl = 4'b0010; end
         4'hC: begin d = a >> 1; fl = 4'b1000; end
         4'hD: begin d = {a[7], a[7:1]}; fl = 4'b1000; end
         4'hE: begin d = a << 1; fl = 4'b1000; end
         default: begin d = 8'h00; fl = 4'b0000; end
      endcase
      return {fl, d};
   endfunction

   assign {afl, alu_out} = alu_f(alu_a, alu_b, alu_fun);

   // Expected stage output for a command, including the div-by-zero rule
   function automatic exp_t exp_calc(input logic [7:0] a,
                                     input logic [7:0] b,
                                     input logic [3:0] f);
      logic [11:0] r;
      exp_t e;
      r    = alu_f(a, b, f);
      e.d  = r[7:0];
      e.fl = r[11:8];
      e.fn = f;
      e.dz = 1'b0;
      if (f == 4'b0011 && b == 8'h00) begin
         e.d  = 8'hFF;
         e.dz = 1'b1;
      end
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp,
                  $time);
      end
   endtask

   // Drive one command; expectation is queued when it is accepted
   task automatic send(input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] f, input exp_t e);
      bit ok;
      ok        = 1'b0;
      cmd_a     = a;
      cmd_b     = b;
      cmd_fun   = f;
      cmd_valid = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            sb.push_back(e);
            ok = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      chk("accept", 32'(ok), 32'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
      chk("drain", 32'(sb.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: compares each handshaken result, checks hold stability
   initial begin
      exp_t       e;
      bit         stall;
      logic [16:0] hd;
      stall = 1'b0;
      hd    = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall = 1'b0;
         end else begin
            if (stall)
               chk("hold_stable",
                   32'({res_valid, res_data, res_flags, res_fun, res_dz}),
                   32'({1'b1, hd}));
            if (res_valid && res_ready) begin
               if (sb.size() == 0) begin
                  chk("unexpected_result", 32'(sb.size()), 32'd1);
               end else begin
                  e = sb.pop_front();
                  chk("result",
                      32'({res_data, res_flags, res_fun, res_dz}),
                      32'(e));
                  hs.push_back(cyc);
               end
            end
            stall = res_valid && !res_ready;
            hd    = {res_data, res_flags, res_fun, res_dz};
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t       e;
      logic [7:0] a0;
      logic [7:0] ra;
      logic [7:0] rb;
      logic [3:0] rf;

      tbl[0]  = '{8'h12, 8'h34, 4'h0, 8'h46, 4'b0001, 1'b0};
      tbl[1]  = '{8'h40, 8'h00, 4'h3, 8'hFF, 4'b0001, 1'b1};
      tbl[2]  = '{8'h40, 8'h04, 4'h3, 8'h10, 4'b0001, 1'b0};
      tbl[3]  = '{8'h55, 8'h55, 4'hA, 8'h01, 4'b0010, 1'b0};
      tbl[4]  = '{8'h81, 8'h00, 4'hE, 8'h02, 4'b1000, 1'b0};
      tbl[5]  = '{8'hAA, 8'h0F, 4'h8, 8'h0A, 4'b0010, 1'b0};
      tbl[6]  = '{8'h10, 8'h20, 4'h1, 8'hF0, 4'b0001, 1'b0};
      tbl[7]  = '{8'h3C, 8'hC3, 4'hF, 8'h00, 4'b0000, 1'b0};
      tbl[8]  = '{8'h03, 8'h05, 4'h2, 8'h0F, 4'b0001, 1'b0};
      tbl[9]  = '{8'h55, 8'h54, 4'hA, 8'h00, 4'b0010, 1'b0};
      tbl[10] = '{8'h05, 8'h09, 4'h4, 8'h01, 4'b0100, 1'b0};
      tbl[11] = '{8'h00, 8'h00, 4'h3, 8'hFF, 4'b0001, 1'b1};

      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_a     = 8'h00;
      cmd_b     = 8'h00;
      cmd_fun   = 4'h0;
      res_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Reset / idle state
      chk("rst_alu_ops", 32'({alu_a, alu_b, alu_fun}), 32'h0000F);
      chk("rst_res", 32'({res_valid, res_data, res_flags, res_fun, res_dz}),
          32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_ready_busy", 32'({cmd_ready, busy}), 32'b10);

      // Single add: latency E0 -> ops after E1 -> res_valid after E2
      res_ready = 1'b1;
      send(8'h12, 8'h34, 4'h0, '{8'h46, 4'b0001, 4'h0, 1'b0});
      chk("lat_e0_valid", 32'(res_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("lat_e1_ops", 32'({alu_a, alu_b, alu_fun}), 32'h12340);
      chk("lat_e1_valid", 32'(res_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("lat_e2_valid", 32'(res_valid), 32'd1);
      drain();

      // Table-driven vectors
      for (int i = 0; i < 12; i++) begin
         e = '{tbl[i].d, tbl[i].fl, tbl[i].f, tbl[i].dz};
         send(tbl[i].a, tbl[i].b, tbl[i].f, e);
         drain();
      end
      chk("idle_ops_kept", 32'({alu_a, alu_b, alu_fun}), 32'h00003);
      chk("idle_busy", 32'(busy), 32'd0);

      // Back-pressure: fill FIFO with one command already in flight
      res_ready = 1'b0;
      a0 = 8'h00;
      for (int i = 0; i < 5; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom_range(0, 7));
         rf = 4'($urandom_range(0, 15));
         if (i == 0) a0 = ra;
         send(ra, rb, rf, exp_calc(ra, rb, rf));
      end
      chk("full_count", 32'(fifo_count), 32'd4);
      chk("full_ready", 32'(cmd_ready), 32'd0);
      chk("full_valid_busy", 32'({res_valid, busy}), 32'b11);
      chk("full_ops_first", 32'(alu_a), 32'(a0));
      cmd_a     = 8'hEE;
      cmd_b     = 8'h01;
      cmd_fun   = 4'h0;
      cmd_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("refuse_ready", 32'(cmd_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      chk("refuse_count", 32'(fifo_count), 32'd4);
      hs.delete();
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_after_pop", 32'({cmd_ready, fifo_count}), 32'({1'b1, 3'd3}));
      drain();
      chk("bp_results", 32'(hs.size()), 32'd5);
      for (int i = 1; i < hs.size(); i++)
         chk("bp_spacing", 32'(hs[i] - hs[i-1]), 32'd2);

      // Reset while in EXEC with two entries queued
      res_ready = 1'b0;
      send(8'h01, 8'h02, 4'h0, exp_calc(8'h01, 8'h02, 4'h0));
      send(8'h03, 8'h04, 4'h0, exp_calc(8'h03, 8'h04, 4'h0));
      send(8'h05, 8'h06, 4'h0, exp_calc(8'h05, 8'h06, 4'h0));
      res_ready = 1'b1;
      send(8'h07, 8'h08, 4'h0, exp_calc(8'h07, 8'h08, 4'h0));
      chk("pre_rst_state", 32'({fifo_count, res_valid, busy}),
          32'({3'd2, 1'b0, 1'b1}));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_count", 32'(fifo_count), 32'd0);
      chk("mid_rst_res", 32'({res_valid, res_dz}), 32'd0);
      chk("mid_rst_idle", 32'({busy, cmd_ready}), 32'b01);
      chk("mid_rst_fun", 32'(alu_fun), 32'hF);
      sb.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      hs.delete();
      repeat (10) @(posedge clk);
      #1;
      chk("post_rst_no_result", 32'({res_valid, busy}), 32'd0);
      chk("post_rst_no_hs", 32'(hs.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Command-issue and result-capture stage that sits directly upstream of the 8-bit combinational ALU. Buffers incoming operation commands in a small FIFO, drives registered operands and function code onto the ALU inputs, and samples the ALU result and flags into a result register. Exposes valid/ready handshakes on both the command side and the result side. Guards the divide-by-zero case.

## Interface
- DEPTH, 4, command FIFO depth; power of 2, ≥2
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept; = (count < DEPTH)
- cmd_a  in  8  operand A
- cmd_b  in  8  operand B
- cmd_fun  in  4  ALU function code
- alu_a  out  8  registered operand A to ALU
- alu_b  out  8  registered operand B to ALU
- alu_fun  out  4  registered function code to ALU
- alu_out  in  8  ALU result, combinational from alu_a/alu_b/alu_fun
- alu_arith, alu_logic, alu_cmp, alu_shift  in  1 each  ALU flags
- res_valid  out  1  result register holds an unconsumed result
- res_ready  in  1  downstream accepts result
- res_data  out  8  captured result
- res_flags  out  4  {shift, cmp, logic, arith}
- res_fun  out  4  function code that produced res_data
- res_dz  out  1  divide-by-zero substitution occurred
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy
- busy  out  1  FSM not in IDLE or FIFO non-empty

## Operation
- FIFO: push on cmd_valid && cmd_ready; pop only by FSM. Pointers wrap modulo DEPTH; count tracks occupancy 0..DEPTH. No bypass: an entry pushed on edge E is poppable no earlier than edge E+1. Push and pop on the same edge are both honoured (count unchanged).
- FSM states: IDLE, EXEC, HOLD.
  - IDLE: if count>0, pop head into alu_a/alu_b/alu_fun, → EXEC; else stay.
  - EXEC: one cycle with operands stable at the ALU. On exit edge, capture alu_out→res_data, flags→res_flags, alu_fun→res_fun; set res_valid; → HOLD.
  - HOLD: res_valid=1. On res_valid && res_ready: clear res_valid; if count>0 pop next head into operand regs and → EXEC, else → IDLE. Without ready: hold all res_* stable.
- Divide-by-zero: if alu_fun==4'b0011 and alu_b==0 at capture, res_data=8'hFF, res_dz=1, and res_flags is taken from the ALU unchanged (arith=1). Otherwise res_dz=0.
- Operand regs retain last popped values while idle; no re-issue.
- Unused ALU codes (4'b1111) pass through; res_data is 0 and res_flags is 0000 as the ALU produces.

## Timing
- Reset (async assert, released synchronously by design): state=IDLE, FIFO empty, fifo_count=0, cmd_ready=1 (combinational), alu_a=alu_b=0, alu_fun=4'b1111, res_valid=0, res_data=0, res_flags=0, res_fun=0, res_dz=0, busy=0.
- Latency: command accepted on edge E0 with FSM in IDLE → operands on alu_* after E1 → res_valid=1 after E2.
- Throughput: one result per 2 cycles with res_ready held high (HOLD→EXEC→HOLD).
- Full: cmd_ready=0 when count==DEPTH; cmd_valid ignored. cmd_ready rises the cycle after a pop from full.
- Reset mid-operation: all queued commands and any pending result are discarded immediately; no partial res_valid pulse.
- res_valid never drops without a handshake. res_data, res_flags, res_fun, and res_dz are constant while res_valid && !res_ready.

## Test plan
- Reset, then idle: all outputs match reset values, cmd_ready=1, busy=0.
- Single add with A=0x12, B=0x34, fun=0000, res_ready=1 → res_valid 2 edges after accept, res_data=0x46, res_flags=0001, res_fun=0000, res_dz=0.
- Back-pressure: res_ready=0, push 5 commands (DEPTH=4) → first pops into EXEC, count reaches 4 with cmd_ready=0 and the 6th is refused, res_* frozen. Release res_ready → 5 results in order, each 2 cycles apart.
- Divide-by-zero: A=0x40, B=0x00, fun=0011 → res_data=0xFF, res_dz=1, res_flags=0001. Next command A=0x40, B=0x04, fun=0011 → 0x10, res_dz=0.
- Compare/shift mix: A=B=0x55 with fun=1010 → 0x01 and flags 0010. fun=1110 with A=0x81 → 0x02 and flags 1000.
- Reset asserted in EXEC with 2 entries queued → immediately fifo_count=0, res_valid=0, state IDLE, and no results emerge after release.
